add_serial_arb: RTL and testbench
=================================

ADD_SERIAL_ARB -- requirements
Module: add_serial_arb

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; count width is clog2(WIDTH).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req  input  2  per-requester request; level, held until granted.
REQ-005 a0, b0  input  WIDTH each  requester 0 operands.
REQ-006 a1, b1  input  WIDTH each  requester 1 operands.
REQ-007 gnt  output  2  one-hot grant pulse, registered.
REQ-008 busy  output  1  high while an operation is accepted and not yet retired.
REQ-009 done  output  1  one-cycle result-valid pulse.
REQ-010 done_id  output  1  requester index owning the current result.
REQ-011 out  output  WIDTH  sum result.
REQ-012 cout  output  1  final carry of the last operation.

Function
REQ-013 The block SHALL share one internal bit-serial adder (1 bit per cycle, LSB first) between two requesters.
REQ-014 FSM states SHALL be IDLE, ADD, DONE; transitions: IDLE->ADD on acceptance; ADD->DONE when count==WIDTH-1; DONE->IDLE unconditionally.
REQ-015 Acceptance SHALL occur on an IDLE-cycle edge with req!=0: latch the winner's operands, clear count and carry, set gnt to winner one-hot for exactly the next cycle.
REQ-016 Arbitration SHALL be round-robin: single request wins outright; with req==2'b11 the requester not granted last wins; after reset requester 0 has priority.
REQ-017 Each ADD cycle SHALL compute sum=a[0]^b[0]^carry, carry=majority(a[0],b[0],carry), shift sum into out MSB and right-shift both operand registers, increment count.
REQ-018 Latency: acceptance edge at cycle T; ADD in cycles T+1..T+WIDTH; done=1 and done_id valid in cycle T+WIDTH+1 only.
REQ-019 out, cout and done_id SHALL hold their values from DONE until the next operation's first ADD edge.
REQ-020 busy SHALL be 1 in ADD and DONE, 0 in IDLE.
REQ-021 req during ADD or DONE SHALL be ignored and not queued; requester must keep req high until gnt.
REQ-022 Minimum spacing SHALL be WIDTH+2 cycles between successive acceptances (no acceptance in DONE).
REQ-023 Arithmetic SHALL be modulo 2^WIDTH with carry-out in cout (unless REQ-028 applies).

Reset
REQ-024 rst SHALL take priority over all other inputs on the same edge.
REQ-025 On rst: state=IDLE, gnt=0, busy=0, done=0, done_id=0, out=0, cout=0, count=0, carry=0, operand registers 0, round-robin pointer to requester 0.
REQ-026 rst during ADD or DONE SHALL discard the in-flight operation; no done pulse SHALL follow.

Configuration
REQ-027 Macro ADD_SERIAL_ARB_SAT_EN controls result saturation.
REQ-028 With ADD_SERIAL_ARB_SAT_EN defined: on the DONE transition, if final carry is 1, out SHALL be forced to all-ones; cout still reports 1.
REQ-029 Without ADD_SERIAL_ARB_SAT_EN: out SHALL be the wrapped modulo-2^WIDTH sum; no saturation logic present.

Verification
REQ-030 req=01, a0=8'h3C, b0=8'h15 -> gnt=01 for 1 cycle, done 9 cycles after acceptance, out=8'h51, cout=0, done_id=0.
REQ-031 req=10, a1=8'hFF, b1=8'h01 -> done_id=1, cout=1, out=8'h00 without macro, out=8'hFF with ADD_SERIAL_ARB_SAT_EN.
REQ-032 req=11 held from reset release -> grants in order 0,1,0,1, each acceptance exactly 10 cycles apart.
REQ-033 req=01 accepted, rst asserted in 4th ADD cycle -> next cycle all outputs 0, no done; req held -> requester 0 regranted on first IDLE edge after rst release.
REQ-034 req1 one-cycle pulse while busy, req0 idle -> no gnt to requester 1, block returns to IDLE and stays idle.

Source files
------------

// File: rtl/add_serial_arb_if.sv
// Request/result bundle for add_serial_arb: two requesters' operands and
// requests in, grant pulse and serial-adder result out.
interface add_serial_arb_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic [1:0]       state_dbg;

  // Handshake: req[i] is a level held until gnt[i] pulses for one cycle; the
  // operands of requester i are sampled on the accepting edge and the result
  // is valid only in the cycle where done is high.
  modport master (
    output req, a0, b0, a1, b1,
    input  gnt, busy, done, done_id, out, cout, state_dbg
  );

  modport slave (
    input  req, a0, b0, a1, b1,
    output gnt, busy, done, done_id, out, cout, state_dbg
  );
endinterface

// File: rtl/add_serial_arb.sv
// Two-requester round-robin front end sharing one LSB-first bit-serial adder.
// Define ADD_SERIAL_ARB_SAT_EN to saturate the result to all-ones on carry-out.
module add_serial_arb #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  add_serial_arb_if.slave    bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             prio;
  logic             owner;

  logic [1:0]       gnt_r;
  logic             busy_r;
  logic             done_r;
  logic             done_id_r;
  logic [WIDTH-1:0] out_r;
  logic             cout_r;

  logic             win;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] out_shift;
  logic [WIDTH-1:0] out_final;
  logic             last_bit;

  // prio names the requester that wins a tie; it flips to the loser of each grant.
  always_comb begin
    win = 1'b0;
    case (bus.req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = prio;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    sum_bit   = opa[0] ^ opb[0] ^ carry;
    carry_nxt = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
    out_shift = {sum_bit, out_r[WIDTH-1:1]};
    last_bit  = (count == LAST_COUNT);
`ifdef ADD_SERIAL_ARB_SAT_EN
    out_final = carry_nxt ? {WIDTH{1'b1}} : out_shift;
`else
    out_final = out_shift;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      carry     <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      prio      <= 1'b0;
      owner     <= 1'b0;
      gnt_r     <= 2'b00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= 1'b0;
      out_r     <= '0;
      cout_r    <= 1'b0;
    end else begin
      gnt_r  <= 2'b00;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            state  <= ADD;
            gnt_r  <= win ? 2'b10 : 2'b01;
            owner  <= win;
            prio   <= ~win;
            opa    <= win ? bus.a1 : bus.a0;
            opb    <= win ? bus.b1 : bus.b0;
            count  <= '0;
            carry  <= 1'b0;
            busy_r <= 1'b1;
          end
        end
        ADD: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= carry_nxt;
          count <= count + CW'(1);
          // out keeps shifting in partial sums; the previous result is gone
          // after the first ADD edge, which is the documented hold window.
          if (last_bit) begin
            state     <= DONE;
            out_r     <= out_final;
            cout_r    <= carry_nxt;
            done_r    <= 1'b1;
            done_id_r <= owner;
          end else begin
            out_r <= out_shift;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.done_id   = done_id_r;
  assign bus.out       = out_r;
  assign bus.cout      = cout_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_add_serial_arb.sv
// Bench for add_serial_arb: directed requests, grant and result scoreboards
// checked by a monitor on the falling clock edge.
module tb_add_serial_arb;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  logic [1:0]   gnt_q[$];
  logic [W+1:0] exp_q[$];

  add_serial_arb_if #(.WIDTH(W)) bus ();

  add_serial_arb #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: grant and result scoreboards
  logic [1:0]   prev_gnt;
  int           last_gnt_cyc;
  logic [1:0]   g_exp;
  logic [W+1:0] r_exp;

  initial begin
    prev_gnt     = 2'b00;
    last_gnt_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst && bus.gnt != 2'b00) begin
        check("gnt_single_cycle", {30'd0, prev_gnt}, 32'd0);
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", {30'd0, bus.gnt}, 32'd0);
        end else begin
          g_exp = gnt_q.pop_front();
          check("gnt_value", {30'd0, bus.gnt}, {30'd0, g_exp});
        end
        last_gnt_cyc = cyc;
      end
      if (!rst && bus.done) begin
        check("done_latency", cyc - last_gnt_cyc, W);
        if (exp_q.size() == 0) begin
          check("done_unexpected", {31'd0, bus.done}, 32'd0);
        end else begin
          r_exp = exp_q.pop_front();
          check("result", {22'd0, bus.done_id, bus.cout, bus.out}, {22'd0, r_exp});
        end
      end
      prev_gnt = bus.gnt;
    end
  end

  // driver tasks
  function automatic logic [W+1:0] model(input logic id, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] o;
    s = {1'b0, a} + {1'b0, b};
    o = s[W-1:0];
`ifdef ADD_SERIAL_ARB_SAT_EN
    if (s[W]) o = '1;
`endif
    return {id, s[W], o};
  endfunction

  task automatic do_reset();
    bus.req = 2'b00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input int id);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.gnt[id]) seen = 1'b1;
    end
    check("gnt_wait", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (!bus.busy) idle = 1'b1;
    end
    check("idle_wait", {31'd0, idle}, 32'd1);
  endtask

  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin
      bus.a0 = a; bus.b0 = b;
    end else begin
      bus.a1 = a; bus.b1 = b;
    end
    gnt_q.push_back(id == 0 ? 2'b01 : 2'b10);
    exp_q.push_back(model(id[0], a, b));
    bus.req[id] = 1'b1;
    wait_gnt(id);
    bus.req[id] = 1'b0;
    wait_idle();
  endtask

  // stimulus
  initial begin
    checks = 0;
    errors = 0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    do_reset();

    check("rst_gnt",     {30'd0, bus.gnt},       32'd0);
    check("rst_busy",    {31'd0, bus.busy},      32'd0);
    check("rst_done",    {31'd0, bus.done},      32'd0);
    check("rst_done_id", {31'd0, bus.done_id},   32'd0);
    check("rst_out",     {24'd0, bus.out},       32'd0);
    check("rst_cout",    {31'd0, bus.cout},      32'd0);
    check("rst_state",   {30'd0, bus.state_dbg}, 32'd0);

    // single requests, including wrap/carry cases
    issue(0, 8'h3C, 8'h15);
    issue(1, 8'hFF, 8'h01);
    issue(0, 8'h80, 8'h80);
    issue(1, 8'h12, 8'h34);
    issue(0, 8'hFF, 8'hFF);
    issue(1, 8'h00, 8'h00);
    issue(0, 8'hA5, 8'h5A);

    // both requesters held from reset release: strict alternation, 10 apart
    do_reset();
    bus.a0 = 8'h3C; bus.b0 = 8'h15;
    bus.a1 = 8'hFF; bus.b1 = 8'h01;
    for (int k = 0; k < 2; k++) begin
      gnt_q.push_back(2'b01); exp_q.push_back(model(1'b0, 8'h3C, 8'h15));
      gnt_q.push_back(2'b10); exp_q.push_back(model(1'b1, 8'hFF, 8'h01));
    end
    bus.req = 2'b11;
    begin
      int prev;
      int n;
      prev = 0;
      n = 0;
      for (int i = 0; i < 80 && n < 4; i++) begin
        @(negedge clk);
        if (bus.gnt != 2'b00) begin
          if (n > 0) check("rr_spacing", cyc - prev, W + 2);
          prev = cyc;
          n++;
        end
      end
      check("rr_grant_count", n, 4);
    end
    bus.req = 2'b00;
    wait_idle();

    // reset in the 4th ADD cycle discards the operation; held req regranted
    bus.a0 = 8'h07; bus.b0 = 8'h00;
    gnt_q.push_back(2'b01);
    bus.req = 2'b01;
    wait_gnt(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_gnt",     {30'd0, bus.gnt},     32'd0);
    check("abort_busy",    {31'd0, bus.busy},    32'd0);
    check("abort_done",    {31'd0, bus.done},    32'd0);
    check("abort_done_id", {31'd0, bus.done_id}, 32'd0);
    check("abort_out",     {24'd0, bus.out},     32'd0);
    check("abort_cout",    {31'd0, bus.cout},    32'd0);
    gnt_q.push_back(2'b01);
    exp_q.push_back(model(1'b0, 8'h07, 8'h00));
    rst = 1'b0;
    @(negedge clk);
    check("regrant", {30'd0, bus.gnt}, 32'd1);
    bus.req = 2'b00;
    wait_idle();

    // requester 1 pulses while busy: ignored, block returns to idle
    bus.a0 = 8'h21; bus.b0 = 8'h43;
    gnt_q.push_back(2'b01);
    exp_q.push_back(model(1'b0, 8'h21, 8'h43));
    bus.req[0] = 1'b1;
    wait_gnt(0);
    bus.req[0] = 1'b0;
    repeat (2) @(negedge clk);
    bus.req[1] = 1'b1;
    @(negedge clk);
    bus.req[1] = 1'b0;
    wait_idle();
    repeat (6) @(negedge clk);
    check("ignored_busy",  {31'd0, bus.busy},      32'd0);
    check("ignored_state", {30'd0, bus.state_dbg}, 32'd0);

    repeat (3) @(negedge clk);
    check("gnt_q_empty", gnt_q.size(), 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
